// File: rtl/sif_pkg.sv
// Shared SIF types: WA address/data words, the buffered write entry, default buffer depth.
package sif_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] data_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wa_entry_t;

    localparam int unsigned SIF_WA_DEPTH_DEF = 8;

endpackage : sif_pkg

// File: rtl/sif_wa_mem.sv
// Entry storage for the WA write buffer: synchronous write port, asynchronous read port.
module sif_wa_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [W-1:0]               i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [W-1:0]               o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : sif_wa_mem

// File: rtl/sif_wa_buffer.sv
// In-order write buffer between the SIF WA port and a slower valid/ready target.
// Build option SIF_WA_DROP_CNT_EN adds the saturating drop_cnt port and counter.
module sif_wa_buffer
    import sif_pkg::*;
#(
    parameter int unsigned DEPTH = SIF_WA_DEPTH_DEF,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wa_wr_s,
    input  logic [AW-1:0]              wa_addr,
    input  logic [DW-1:0]              wa_data_wr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AW-1:0]              out_addr,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
`ifdef SIF_WA_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = PW + 1;
    localparam int unsigned EW    = AW + DW;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [EW-1:0]    w_wentry;
    logic [EW-1:0]    w_rentry;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    // A pop at the same edge frees the slot, so a write at full is still accepted.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = wa_wr_s && (!w_full || w_pop);
    assign w_drop = wa_wr_s && w_full && !w_pop;

    assign w_wentry = {wa_addr, wa_data_wr};

    sif_wa_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !rst),
        .i_waddr (r_wr_ptr[PW-1:0]),
        .i_wdata (w_wentry),
        .i_raddr (r_rd_ptr[PW-1:0]),
        .o_rdata (w_rentry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_overflow <= w_drop;
        end
    end

`ifdef SIF_WA_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // Status and head entry are functions of registered pointers only.
    assign out_valid = !w_empty;
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign out_addr  = w_rentry[EW-1:DW];
    assign out_data  = w_rentry[DW-1:0];

endmodule : sif_wa_buffer

// File: tb/tb_sif_wa_buffer.sv
// Randomized scoreboard bench for sif_wa_buffer against a queue-based reference model.
module tb_sif_wa_buffer;
    import sif_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wa_wr_s = 1'b1;
    logic [15:0] wa_addr = '0;
    logic [15:0] wa_data_wr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef SIF_WA_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    sif_wa_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wa_wr_s    (wa_wr_s),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
`ifdef SIF_WA_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is a bounded queue of writes.
    wa_entry_t   exp_q[$];
    logic        exp_ovf  = 1'b0;
    int unsigned exp_drops = 0;
    bit          started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare at the falling edge, then predict the coming rising edge.
    always @(negedge clk) begin
        bit        pop;
        bit        push;
        bit        drop;
        wa_entry_t e;
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("empty",     32'(empty),     32'(exp_q.size() == 0));
            chk("full",      32'(full),      32'(exp_q.size() == DEPTH));
            chk("level",     32'(level),     32'(exp_q.size()));
            chk("overflow",  32'(overflow),  32'(exp_ovf));
`ifdef SIF_WA_DROP_CNT_EN
            chk("drop_cnt",  32'(drop_cnt),  32'(exp_drops > 32'hFFFF ? 32'hFFFF : exp_drops));
`endif
            if (exp_q.size() != 0) begin
                chk("out_addr", 32'(out_addr), 32'(exp_q[0].addr));
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            exp_drops = 0;
            started   = 1'b1;
        end else if (started) begin
            pop  = (exp_q.size() != 0) && out_ready;
            push = wa_wr_s && ((exp_q.size() < DEPTH) || pop);
            drop = wa_wr_s && !push;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                e.addr = wa_addr;
                e.data = wa_data_wr;
                exp_q.push_back(e);
            end
            exp_ovf = drop;
            if (drop) exp_drops++;
        end
    end

    task automatic cyc(input bit r, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit rdy);
        @(posedge clk);
        #1;
        rst        = r;
        wa_wr_s    = wr;
        wa_addr    = a;
        wa_data_wr = d;
        out_ready  = rdy;
    endtask

    initial begin
        // Reset held two cycles while the WA side keeps writing.
        cyc(1, 1, 16'h1111, 16'h2222, 0);
        cyc(1, 1, 16'h3333, 16'h4444, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Single write, consumed immediately.
        cyc(0, 1, 16'h0010, 16'hBEEF, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Fill with the target stalled, then overflow by three.
        for (int i = 0; i < 8; i++) cyc(0, 1, 16'(i), 16'hA000 + 16'(i), 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h00F0 + 16'(i), 16'hDEAD, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        // Write at full with a pop at the same edge: accepted.
        cyc(0, 1, 16'h0055, 16'h5555, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 1);

        // Hold level 4 with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 16'h0200 + 16'(i), 16'hD000 + 16'(i), 1);
        repeat (6) cyc(0, 0, 0, 0, 1);

        // Reset with five entries in flight, then a fresh write.
        for (int i = 0; i < 5; i++) cyc(0, 1, 16'h0300 + 16'(i), 16'hE000 + 16'(i), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 16'h0400, 16'hF00D, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // Randomized traffic with varying write and ready density.
        for (int i = 0; i < 3000; i++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = ((i / 300) % 2 == 0) ? 80 : 40;
            rd_pct = ((i / 450) % 2 == 0) ? 30 : 85;
            cyc(($urandom_range(0, 249) == 0),
                ($urandom_range(0, 99) < wr_pct),
                16'($urandom), 16'($urandom),
                ($urandom_range(0, 99) < rd_pct));
        end
        repeat (12) cyc(0, 0, 0, 0, 1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sif_wa_buffer
